// File: rtl/ahb2apb_bridge.sv
// ----------------------------------------------------------------------------
// ahb2apb_bridge
//   AHB-Lite slave to APB4 master bridge. Each selected AHB transfer becomes a
//   single APB SETUP/ACCESS sequence; wait states are inserted via HREADYOUT,
//   PRDATA is returned as HRDATA, and PSLVERR or an ACCESS timeout is turned
//   into a two-cycle AHB ERROR response. Unsupported sizes (HSIZE > word) get
//   the ERROR response without any APB cycle.
//
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HSEL/HADDR/HTRANS/HWRITE AHB address phase (HSEL from the decoder)
//   HSIZE/HWDATA/HREADY      AHB size, write data, bus-level ready
//   HREADYOUT/HRESP/HRDATA   AHB slave response
//   PSEL/PENABLE/PADDR       APB control and address
//   PWRITE/PWDATA/PSTRB      APB direction, write data, byte strobes
//   PRDATA/PREADY/PSLVERR    APB completer response
// ----------------------------------------------------------------------------
module ahb2apb_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter int unsigned TO_CNT_W    = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam bit                  TO_EN   = (TIMEOUT_CYC != 0);
    // Timeout fires in the ACCESS cycle whose count (before increment) is the last allowed one.
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [3:0]          r_pstrb;
    logic [TO_CNT_W-1:0] r_to_cnt;

    logic                w_accept;
    logic                w_size_ok;
    logic                w_to_hit;
    logic [3:0]          w_strb;
    logic                w_unused;

    // HTRANS[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY, which the bridge treats alike.
    assign w_unused  = HTRANS[0];

    assign w_accept  = HSEL & HREADY & HTRANS[1];
    assign w_size_ok = (HSIZE <= 3'd2);
    assign w_to_hit  = TO_EN && !PREADY && (r_to_cnt == TO_LAST);

    assign PADDR  = r_paddr;
    assign PWRITE = r_pwrite;
    assign PSTRB  = r_pstrb;
    assign PWDATA = HWDATA;

    always_comb begin
        w_strb = '0;
        case (HSIZE[1:0])
            2'd0:    w_strb = 4'b0001 << HADDR[1:0];
            2'd1:    w_strb = 4'b0011 << {HADDR[1], 1'b0};
            2'd2:    w_strb = 4'b1111;
            default: w_strb = '0;
        endcase
        if (!HWRITE) begin
            w_strb = '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_size_ok ? S_SETUP : S_ERR1;
                end
            end
            S_SETUP: begin
                PSEL      = 1'b1;
                HREADYOUT = 1'b0;
                w_next    = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                HRDATA  = PRDATA;
                if (PREADY) begin
                    if (PSLVERR) begin
                        HREADYOUT = 1'b0;
                        w_next    = S_ERR1;
                    end else if (w_accept) begin
                        w_next = w_size_ok ? S_SETUP : S_ERR1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    HREADYOUT = 1'b0;
                    if (w_to_hit) begin
                        w_next = S_ERR1;
                    end
                end
            end
            S_ERR1: begin
                HRESP     = 1'b1;
                HREADYOUT = 1'b0;
                w_next    = S_ERR2;
            end
            S_ERR2: begin
                HRESP = 1'b1;
                if (w_accept) begin
                    w_next = w_size_ok ? S_SETUP : S_ERR1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // SETUP is only ever entered from an accepted transfer, so that transition doubles
    // as the capture strobe for the address-phase controls and the timeout clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pstrb  <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_SETUP) begin
                r_paddr  <= HADDR;
                r_pwrite <= HWRITE;
                r_pstrb  <= w_strb;
                r_to_cnt <= '0;
            end else if (r_state == S_ACCESS && !PREADY) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule
